instruction_fetch: RTL

//  IF stage of the 5-stage MIPS pipeline: holds the PC, fetches from an internal

---
 rtl/instruction_fetch.sv | 91 +++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// IF stage: PC register, synchronous read-first instruction memory with loader port,
// next-PC mux (stall / branch / jump / register jump), flush blanking and HALT detection.
module instruction_fetch #(
  parameter int         PC_BITS          = 11,
  parameter int         INSTRUCTION_BITS = 32,
  parameter int         MEM_DEPTH        = 2**PC_BITS,
  parameter logic [5:0] HALT_OPCODE      = 6'h3F
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_pc_write,
  input  logic [1:0]                  i_pc_src,
  input  logic [PC_BITS-1:0]          i_branch_target,
  input  logic [PC_BITS-1:0]          i_jump_target,
  input  logic [PC_BITS-1:0]          i_reg_target,
  input  logic                        i_flush,
  input  logic                        i_mem_wr_en,
  input  logic [PC_BITS-1:0]          i_mem_wr_addr,
  input  logic [INSTRUCTION_BITS-1:0] i_mem_wr_data,
  output logic [PC_BITS-1:0]          o_pc_next,
  output logic [INSTRUCTION_BITS-1:0] o_instruction,
  output logic                        o_valid,
  output logic                        o_halt,
  output logic [1:0]                  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                      state_q;
  logic [PC_BITS-1:0]          pc_q;
  logic [PC_BITS-1:0]          pc_d;
  logic [PC_BITS-1:0]          pc_inc;
  logic [INSTRUCTION_BITS-1:0] mem [MEM_DEPTH];
  logic [INSTRUCTION_BITS-1:0] mem_q;
  logic                        halt_hit;

  assign pc_inc      = pc_q + PC_BITS'(1);
  assign o_pc_next   = pc_inc;
  assign o_dbg_state = state_q;

  // o_valid has no ready: the consumer takes o_instruction on every edge where o_valid=1.
  assign o_valid       = (state_q == ST_RUN) && i_enable && !i_flush;
  assign o_instruction = o_valid ? mem_q : '0;
  assign halt_hit      = o_valid && (mem_q[INSTRUCTION_BITS-1 -: 6] == HALT_OPCODE);

  // PC moves only in RUN when enabled and not stalled; a HALT freezes it on the halting PC.
  always_comb begin
    pc_d = pc_q;
    if ((state_q == ST_RUN) && i_enable && i_pc_write && !halt_hit) begin
      unique case (i_pc_src)
        2'b00:   pc_d = pc_inc;
        2'b01:   pc_d = i_branch_target;
        2'b10:   pc_d = i_jump_target;
        default: pc_d = i_reg_target;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PRIME;
      pc_q    <= '0;
      o_halt  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_PRIME: if (i_enable) state_q <= ST_RUN;
        ST_RUN: begin
          pc_q <= pc_d;
          if (halt_hit) begin
            state_q <= ST_HALTED;
            o_halt  <= 1'b1;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_PRIME;
      endcase
    end
  end

  // Memory is not reset so loaded programs survive rst; read-first on address collision.
  always_ff @(posedge clk) begin
    if (i_mem_wr_en) mem[i_mem_wr_addr] <= i_mem_wr_data;
    mem_q <= mem[pc_d];
  end

endmodule
